// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input into a circular FIFO,
// serialised LSB first with optional parity and one or two stop bits.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          Tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 tick;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  state_t               state;
  state_t               state_d;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BAUD_W-1:0]    baud_d;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_d;
  logic                 stop_idx;
  logic                 stop_idx_d;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_bit;
  logic                 par_d;
  logic                 tx_d;

  // in_ready is decoded from the registered count only, so a full FIFO never
  // accepts a word even on the edge that pops.
  assign in_ready = (fifo_count < DEPTH_CNT);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign head_par = (PARITY == 2) ? ~^head : ^head;
  assign tick     = (baud_cnt == BAUD_LAST);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      Tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      shift    <= shift_d;
      par_bit  <= par_d;
      Tx       <= tx_d;
    end
  end

  // Tx is registered from the next state so it only moves on bit boundaries.
  always_comb begin
    state_d    = state;
    baud_d     = baud_cnt;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    shift_d    = shift;
    par_d      = par_bit;
    load       = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;

    if (state != ST_IDLE) begin
      baud_d = tick ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            state_d    = (PARITY != 0) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx + IDX_W'(1);
            shift_d   = shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_idx == LAST_STOP) begin
            if (fifo_count != '0) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = head_par;
      baud_d  = '0;
      state_d = ST_START;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2)
// at four clocks per bit, checked against hand vectors and a frame model.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] in_data_a [4];
  logic [3:0] in_valid;
  logic [3:0] in_ready_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [2:0] fc_a [4];

  int cfgDb   [4] = '{8, 8, 8, 7};
  int cfgPar  [4] = '{0, 1, 2, 0};
  int cfgStop [4] = '{1, 1, 1, 2};

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .reset(reset), .in_data(in_data_a[0][7:0]), .in_valid(in_valid[0]),
    .in_ready(in_ready_w[0]), .Tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(fc_a[0]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .reset(reset), .in_data(in_data_a[1][7:0]), .in_valid(in_valid[1]),
    .in_ready(in_ready_w[1]), .Tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(fc_a[1]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .reset(reset), .in_data(in_data_a[2][7:0]), .in_valid(in_valid[2]),
    .in_ready(in_ready_w[2]), .Tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(fc_a[2]));

  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .reset(reset), .in_data(in_data_a[3][6:0]), .in_valid(in_valid[3]),
    .in_ready(in_ready_w[3]), .Tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(fc_a[3]));

  typedef struct {
    int          cfg;
    logic [8:0]  data;
    int          len;
    logic [11:0] pattern;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Frame as a list of line levels, built from the framing rules alone.
  function automatic logic [11:0] modelFrame(input int cfg, input logic [8:0] d, output int len);
    logic [11:0] f;
    int ones;
    int k;
    f    = '0;
    ones = 0;
    k    = 1;
    for (int i = 0; i < cfgDb[cfg]; i++) begin
      f[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (cfgPar[cfg] != 0) begin
      f[k] = (cfgPar[cfg] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      k++;
    end
    for (int s = 0; s < cfgStop[cfg]; s++) begin
      f[k] = 1'b1;
      k++;
    end
    len = k;
    return f;
  endfunction

  // Starts at the next falling edge; returns 1 ns after the accepting rising edge.
  task automatic applyStimulus(input int cfg, input logic [8:0] d);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    @(negedge clk);
    in_data_a[cfg] = d;
    in_valid[cfg]  = 1'b1;
    while (!done) begin
      done = in_ready_w[cfg];
      @(posedge clk);
      guard++;
      if (!done) begin
        if (guard > 2000) begin
          checkOutput($sformatf("push timeout cfg%0d", cfg), 32'd0, 32'd1);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    #1 in_valid[cfg] = 1'b0;
  endtask

  task automatic checkBits(input int cfg, input logic [11:0] pattern, input int len, input bit primed);
    int bad;
    for (int b = 0; b < len; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (!(primed && b == 0 && c == 0)) @(negedge clk);
        if (tx_w[cfg] !== pattern[b] || busy_w[cfg] !== 1'b1) bad++;
      end
      checkOutput($sformatf("cfg%0d bit%0d bad cycles", cfg, b), bad, 0);
    end
  endtask

  task automatic expectFrame(input int cfg, input logic [11:0] pattern, input int len);
    @(negedge clk);
    checkOutput($sformatf("cfg%0d latency tx", cfg), tx_w[cfg], 1);
    checkOutput($sformatf("cfg%0d latency busy", cfg), busy_w[cfg], 0);
    checkBits(cfg, pattern, len, 1'b0);
    @(negedge clk);
    checkOutput($sformatf("cfg%0d end busy", cfg), busy_w[cfg], 0);
    checkOutput($sformatf("cfg%0d end tx", cfg), tx_w[cfg], 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] pat;
    int          len;
    int          cfg;
    logic [8:0]  d;
    bit          found;

    vecs[0] = '{0, 9'h0A5, 10, 12'h34A};
    vecs[1] = '{1, 9'h007, 11, 12'h60E};
    vecs[2] = '{2, 9'h007, 11, 12'h40E};
    vecs[3] = '{3, 9'h055, 10, 12'h3AA};
    vecs[4] = '{0, 9'h000, 10, 12'h200};
    vecs[5] = '{0, 9'h0FF, 10, 12'h3FE};
    vecs[6] = '{1, 9'h000, 11, 12'h400};
    vecs[7] = '{2, 9'h0FF, 11, 12'h7FE};

    in_valid = '0;
    for (int i = 0; i < 4; i++) in_data_a[i] = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset tx", tx_w[0], 1);
    checkOutput("reset busy", busy_w[0], 0);
    checkOutput("reset in_ready", in_ready_w[0], 1);
    checkOutput("reset fifo_count", fc_a[0], 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cfg, vecs[i].data);
      expectFrame(vecs[i].cfg, vecs[i].pattern, vecs[i].len);
    end

    for (int r = 0; r < 8; r++) begin
      cfg = int'($urandom_range(0, 3));
      d   = 9'($urandom_range(0, (1 << cfgDb[cfg]) - 1));
      pat = modelFrame(cfg, d, len);
      applyStimulus(cfg, d);
      expectFrame(cfg, pat, len);
    end

    // Six words with in_valid held: the FIFO fills, the sixth waits, frames abut.
    fork
      begin
        for (int w = 1; w <= 6; w++) begin
          applyStimulus(0, 9'(w));
          if (w == 5) begin
            @(negedge clk);
            checkOutput("full fifo_count", fc_a[0], 4);
            checkOutput("full in_ready", in_ready_w[0], 0);
          end
        end
      end
      begin
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          if (tx_w[0] === 1'b0) found = 1'b1;
        end
        checkOutput("b2b start seen", found, 1);
        for (int f = 1; f <= 6; f++) begin
          pat = modelFrame(0, 9'(f), len);
          checkBits(0, pat, len, (f == 1) && found);
        end
      end
    join
    @(negedge clk);
    checkOutput("b2b end busy", busy_w[0], 0);
    checkOutput("b2b end fifo_count", fc_a[0], 0);
    checkOutput("b2b end in_ready", in_ready_w[0], 1);

    // Reset during data bit 3 of 0x11 with two words still queued.
    applyStimulus(0, 9'h011);
    applyStimulus(0, 9'h022);
    applyStimulus(0, 9'h033);
    repeat (17) @(negedge clk);
    checkOutput("mid tx before reset", tx_w[0], 0);
    checkOutput("mid fifo_count before reset", fc_a[0], 2);
    #1 reset = 1'b0;
    #1;
    checkOutput("async reset tx", tx_w[0], 1);
    checkOutput("async reset busy", busy_w[0], 0);
    checkOutput("async reset fifo_count", fc_a[0], 0);
    checkOutput("async reset in_ready", in_ready_w[0], 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no resume tx", tx_w[0], 1);
    checkOutput("no resume busy", busy_w[0], 0);
    pat = modelFrame(0, 9'h03C, len);
    applyStimulus(0, 9'h03C);
    expectFrame(0, pat, len);
    checkOutput("post reset fifo_count", fc_a[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
